endian_swap_stream: RTL and testbench
=====================================

// Module: endian_swap_stream
//
// PURPOSE
// - Streaming, parametrised successor to the fixed 48-bit combinational bit-reverser.
// - Reorders WIDTH-bit beats on a valid/ready stream. Four modes: pass, full bit-reverse, lane swap, bit-reverse within each lane.
// - Mode is locked per frame, framed by in_last. Output is registered through a 2-entry skid buffer.
// - Sits between the packet parser and the crypto datapath in the EmbeddedSec pipeline.
//
// PARAMETERS
// - WIDTH    48  beat width in bits; must be a multiple of LANE (elaboration error otherwise)
// - LANE     8   lane width in bits for the lane-swap and in-lane reverse modes
// - CNT_W    16  width of the saturating beat counter
//
// PORTS
// - clk          in   1          rising-edge clock
// - rst_n        in   1          asynchronous active-low reset
// - in_valid     in   1          input beat valid
// - in_ready     out  1          input beat accepted when in_valid && in_ready
// - in_data      in   WIDTH      input beat
// - in_last      in   1          final beat of the frame
// - mode         in   2          00 pass, 01 bit-reverse, 10 lane-swap, 11 in-lane bit-reverse
// - out_valid    out  1          output beat valid
// - out_ready    in   1          downstream accept
// - out_data     out  WIDTH      reordered beat
// - out_last     out  1          in_last carried with the beat
// - out_mode     out  2          mode applied to this beat
// - beat_cnt     out  CNT_W      accepted input beats; saturates at all-ones
// - clr_cnt      in   1          synchronous clear of beat_cnt; wins over an increment in the same cycle
//
// BEHAVIOUR
// - Reset (async assert, sync release): buffer empty, out_valid=0, out_data=0, out_last=0, out_mode=0, beat_cnt=0, FSM=IDLE.
// - in_ready is registered and equals "buffer has >=1 free entry". It is 0 during reset.
// - Transform functions, with i = bit index, L = LANE, N = WIDTH/L:
//   - mode 01: out[i] = in[WIDTH-1-i]; WIDTH=48 matches the legacy 48-bit swap.
//   - mode 10: lane k moves to lane N-1-k; bit order within a lane is kept.
//   - mode 11: lane position is kept; bits inside each lane are reversed.
// - Latency: an accepted beat appears on out_* the next cycle if the buffer was empty. Throughput is 1 beat/cycle while out_ready=1.
// - Buffer is a 2-entry FIFO. Accept and pop in the same cycle leave occupancy unchanged. Beat order is preserved.
// - Full (2 entries): in_ready=0 next cycle, and no beat is dropped. Empty: out_valid=0, and out_data holds its last value.
// - out_* must remain stable while out_valid && !out_ready.
// - FSM IDLE / IN_FRAME:
//   - IDLE, accept with !in_last: latch mode into frame_mode and go to IN_FRAME.
//   - IDLE, accept with in_last: single-beat frame; use the current mode and stay in IDLE.
//   - IN_FRAME: every beat uses frame_mode; changes on the mode port are ignored.
//   - IN_FRAME, accept with in_last: return to IDLE.
// - beat_cnt increments on each accepted beat, holds at 2^CNT_W-1, and is cleared by clr_cnt.
// - An illegal mode value is impossible, since all 4 encodings are defined.
// - Reset mid-frame: frame is abandoned, buffered beats are discarded, FSM=IDLE. The next beat starts a new frame.
//
// STRUCTURE
// - Package endian_swap_pkg holds:
//   - mode localparams MODE_PASS, MODE_BITREV, MODE_LANESWAP, MODE_LANEREV
//   - typedef swap_mode_t (2 bits)
//   - pure function swap_beat(data, mode), parametrised by WIDTH and LANE
// - One sub-module, skid_fifo2 (WIDTH+3 bits: data, last, mode), holds the buffer logic.
// - Top level holds the FSM, transform and counter. The transform is combinational in front of skid_fifo2.
//
// TESTING
// - Mode 01, WIDTH=48, single beat 48'h0000_0000_0001, last=1 -> out_data 48'h8000_0000_0000 one cycle later, out_mode=01.
// - Mode 10, in 48'h0102_0304_0506 -> out 48'h0605_0403_0201. Mode 11, in 48'h0000_0000_0001 -> out 48'h0000_0000_0080.
// - Frame of 3 beats in mode 10, with mode driven to 01 on beats 2-3 -> all 3 outputs lane-swapped, out_last only on beat 3.
// - out_ready=0 for 4 cycles under continuous in_valid:
//   - in_ready drops after 2 accepts and beat_cnt=2.
//   - on release, beats emerge in order with no loss or duplication.
// - CNT_W=4: 16 beats -> beat_cnt holds 4'hF. clr_cnt pulsed together with an accept -> beat_cnt=0.
// - rst_n asserted mid-frame with 2 beats buffered:
//   - out_valid=0 immediately and beat_cnt=0.
//   - the next beat after release uses the newly sampled mode.

Source files
------------

// File: rtl/endian_swap_pkg.sv
// Shared mode encodings and the beat reordering function for endian_swap_stream.
package endian_swap_pkg;

    localparam int unsigned MAX_W = 256;

    typedef logic [1:0] swap_mode_t;

    localparam swap_mode_t MODE_PASS     = 2'b00;
    localparam swap_mode_t MODE_BITREV   = 2'b01;
    localparam swap_mode_t MODE_LANESWAP = 2'b10;
    localparam swap_mode_t MODE_LANEREV  = 2'b11;

    // Operates on a MAX_W container; only the low 'width' bits are meaningful,
    // callers pass their WIDTH/LANE parameters as constants.
    function automatic logic [MAX_W-1:0] swap_beat(
        input logic [MAX_W-1:0] data,
        input swap_mode_t       mode,
        input int unsigned      width,
        input int unsigned      lane
    );
        logic [MAX_W-1:0] res;
        int unsigned      n;
        int unsigned      k;
        int unsigned      b;
        res = '0;
        n   = width / lane;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            k = i / lane;
            b = i % lane;
            if (i < width) begin
                case (mode)
                    MODE_PASS:     res[i] = data[i];
                    MODE_BITREV:   res[i] = data[width-1-i];
                    MODE_LANESWAP: res[i] = data[(n-1-k)*lane + b];
                    default:       res[i] = data[k*lane + lane-1-b];
                endcase
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry registered FIFO; the head entry drives the outputs directly.
module skid_fifo2 #(
    parameter int unsigned DW = 51
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic [1:0]    r_count;
    logic [1:0]    w_count_nxt;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [DW-1:0] w_head_nxt;
    logic [DW-1:0] w_tail_nxt;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_valid && r_ready;
    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;

    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_count)
            2'd0: begin
                if (w_push) begin
                    w_head_nxt  = i_data;
                    w_count_nxt = 2'd1;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    w_head_nxt = i_data;
                end else if (w_push) begin
                    w_tail_nxt  = i_data;
                    w_count_nxt = 2'd2;
                end else if (w_pop) begin
                    w_count_nxt = 2'd0;
                end
            end
            default: begin
                // ready is low whenever two entries are held, so only a pop can occur
                if (w_pop) begin
                    w_head_nxt  = r_tail;
                    w_count_nxt = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/endian_swap_stream.sv
// Streaming beat reorderer: per-frame mode lock, combinational transform, 2-entry output buffer.
module endian_swap_stream
    import endian_swap_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned LANE  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] beat_cnt,
    input  logic             clr_cnt
);

    if ((LANE == 0) || (WIDTH > MAX_W) || ((WIDTH % LANE) != 0)) begin : g_bad_params
        $error("endian_swap_stream: WIDTH must be a non-zero multiple of LANE and at most MAX_W");
    end

    typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    swap_mode_t       r_frame_mode;
    swap_mode_t       w_frame_mode_nxt;
    swap_mode_t       w_eff_mode;
    logic             w_accept;
    logic [MAX_W-1:0] w_din_ext;
    logic [MAX_W-1:0] w_swap_ext;
    logic [WIDTH-1:0] w_swapped;
    logic [CNT_W-1:0] r_cnt;

    assign w_accept   = in_valid && in_ready;
    assign w_eff_mode = (r_state == ST_IN_FRAME) ? r_frame_mode : mode;

    always_comb begin
        w_din_ext            = '0;
        w_din_ext[WIDTH-1:0] = in_data;
    end

    assign w_swap_ext = swap_beat(w_din_ext, w_eff_mode, WIDTH, LANE);
    assign w_swapped  = w_swap_ext[WIDTH-1:0];

    if (WIDTH < MAX_W) begin : g_hi
        logic [MAX_W-WIDTH-1:0] w_unused_hi;
        assign w_unused_hi = w_swap_ext[MAX_W-1:WIDTH];
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_mode_nxt = r_frame_mode;
        case (r_state)
            ST_IDLE: begin
                // a single-beat frame uses the live mode and never leaves IDLE
                if (w_accept && !in_last) begin
                    w_state_nxt      = ST_IN_FRAME;
                    w_frame_mode_nxt = mode;
                end
            end
            ST_IN_FRAME: begin
                if (w_accept && in_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_frame_mode <= MODE_PASS;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_mode <= w_frame_mode_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign beat_cnt = r_cnt;

    skid_fifo2 #(
        .DW(WIDTH + 3)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(in_valid),
        .o_ready(in_ready),
        .i_data ({w_swapped, in_last, w_eff_mode}),
        .o_valid(out_valid),
        .i_ready(out_ready),
        .o_data ({out_data, out_last, out_mode})
    );

endmodule

// File: tb/tb_endian_swap_stream.sv
// Bench for endian_swap_stream: vector table, directed corner sequences, randomized scoreboard run.
module tb_endian_swap_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        in_last;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        out_last;
    logic [1:0]  out_mode;
    logic [15:0] beat_cnt;
    logic        clr_cnt;

    logic        o4_in_ready;
    logic        o4_out_valid;
    logic [47:0] o4_out_data;
    logic        o4_out_last;
    logic [1:0]  o4_out_mode;
    logic [3:0]  o4_beat_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    endian_swap_stream #(.WIDTH(48), .LANE(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_mode(out_mode), .beat_cnt(beat_cnt), .clr_cnt(clr_cnt)
    );

    endian_swap_stream #(.WIDTH(48), .LANE(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o4_in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode), .out_valid(o4_out_valid),
        .out_ready(out_ready), .out_data(o4_out_data), .out_last(o4_out_last),
        .out_mode(o4_out_mode), .beat_cnt(o4_beat_cnt), .clr_cnt(clr_cnt)
    );

    // Reference transform built from streaming operators on whole beats.
    function automatic logic [47:0] ref_swap(input logic [47:0] d, input logic [1:0] m);
        logic [47:0] lanes;
        logic [47:0] r;
        lanes = {<<8{d}};
        case (m)
            2'd0:    r = d;
            2'd1:    r = {<<{d}};
            2'd2:    r = lanes;
            default: r = {<<{lanes}};
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [47:0] d;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] fd [3];
        logic [47:0] bq [$];
        logic [50:0] sb [$];
        logic [63:0] rnd;
        logic [47:0] m_shown;
        logic [15:0] m_cnt;
        logic        m_in_frame;
        logic [1:0]  m_fmode;
        logic [1:0]  eff;
        logic        acc_now;
        int          got;
        int          acc;

        vecs[0] = '{2'd1, 48'h0000_0000_0001, 48'h8000_0000_0000};
        vecs[1] = '{2'd2, 48'h0102_0304_0506, 48'h0605_0403_0201};
        vecs[2] = '{2'd3, 48'h0000_0000_0001, 48'h0000_0000_0080};
        vecs[3] = '{2'd0, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC};
        vecs[4] = '{2'd1, 48'hF000_0000_0000, 48'h0000_0000_000F};
        vecs[5] = '{2'd3, 48'h0102_0304_0506, 48'h8040_C020_A060};
        vecs[6] = '{2'd2, 48'hA1B2_C3D4_E5F6, 48'hF6E5_D4C3_B2A1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        mode = 2'd0; out_ready = 1'b0; clr_cnt = 1'b0;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_last",  64'(out_last),  64'(0));
        chk("rst_out_mode",  64'(out_mode),  64'(0));
        chk("rst_beat_cnt",  64'(beat_cnt),  64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 64'(in_ready), 64'(1));

        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = vecs[i].d; mode = vecs[i].m;
            in_last = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("vec_valid", 64'(out_valid), 64'(1));
            chk("vec_data",  64'(out_data),  64'(vecs[i].exp));
            chk("vec_mode",  64'(out_mode),  64'(vecs[i].m));
            chk("vec_last",  64'(out_last),  64'(1));
            tick();
        end
        chk("empty_valid",     64'(out_valid), 64'(0));
        chk("empty_data_hold", 64'(out_data),  64'(vecs[6].exp));
        chk("cnt_after_vecs",  64'(beat_cnt),  64'(7));

        // Three-beat frame: mode port changes after the first beat must be ignored.
        fd[0] = 48'h0123_4567_89AB; fd[1] = 48'hDEAD_BEEF_0042; fd[2] = 48'h55AA_33CC_0F0F;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = fd[k]; mode = (k == 0) ? 2'd2 : 2'd1; in_last = (k == 2);
            tick();
            chk("frame_valid", 64'(out_valid), 64'(1));
            chk("frame_data",  64'(out_data),  64'(ref_swap(fd[k], 2'd2)));
            chk("frame_mode",  64'(out_mode),  64'(2));
            chk("frame_last",  64'(out_last),  64'(k == 2));
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        chk("frame_drained", 64'(out_valid), 64'(0));

        // Backpressure: four cycles of stall under continuous valid.
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        chk("clr_cnt", 64'(beat_cnt), 64'(0));
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0; in_last = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = 48'(32'h100 + c);
            chk("stall_in_ready", 64'(in_ready), 64'(c < 2));
            if (in_ready) bq.push_back(in_data);
            tick();
        end
        chk("stall_beat_cnt",  64'(beat_cnt), 64'(2));
        chk("stall_hold_data", 64'(out_data), 64'(48'h100));
        in_valid = 1'b0; out_ready = 1'b1; got = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) begin
                got++;
                if (bq.size() > 0) chk("stall_order", 64'(out_data), 64'(bq.pop_front()));
            end
            tick();
        end
        chk("stall_count", 64'(got), 64'(2));

        // Counter saturation on the CNT_W=4 instance and clear-over-increment.
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; in_last = 1'b1; mode = 2'd0; acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_data = 48'(i);
            if (in_ready) acc++;
            tick();
            if (i == 15) chk("cnt4_at_16", 64'(o4_beat_cnt), 64'(15));
        end
        in_valid = 1'b0;
        chk("throughput_accepts", 64'(acc), 64'(20));
        chk("cnt16_at_20", 64'(beat_cnt), 64'(20));
        chk("cnt4_at_20",  64'(o4_beat_cnt), 64'(15));
        in_valid = 1'b1; clr_cnt = 1'b1;
        tick();
        in_valid = 1'b0; clr_cnt = 1'b0;
        chk("clr_wins_16", 64'(beat_cnt),    64'(0));
        chk("clr_wins_4",  64'(o4_beat_cnt), 64'(0));
        tick(); tick();

        // Reset mid-frame with two beats buffered.
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'd2; in_last = 1'b0;
        in_data = 48'hAAAA; tick();
        in_data = 48'hBBBB; mode = 2'd1; tick();
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'(1));
        chk("pre_reset_cnt",   64'(beat_cnt),  64'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_cnt",   64'(beat_cnt),  64'(0));
        chk("midrst_data",  64'(out_data),  64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_ready", 64'(in_ready), 64'(1));
        mode = 2'd3; in_data = 48'h1; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_mode", 64'(out_mode), 64'(3));
        chk("post_rst_data", 64'(out_data), 64'(48'h80));
        tick();

        // Randomized run against the queue-based model.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick(); tick();
        m_shown = '0; m_cnt = '0; m_in_frame = 1'b0; m_fmode = 2'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rnd       = {$urandom(), $urandom()};
            in_data   = rnd[47:0];
            in_valid  = ($urandom() % 10) < 7;
            in_last   = ($urandom() % 10) < 3;
            out_ready = ($urandom() % 10) < 6;
            clr_cnt   = ($urandom() % 40) == 0;
            mode      = 2'($urandom() % 4);
            @(negedge clk);
            chk("rnd_valid", 64'(out_valid), 64'(sb.size() > 0));
            if (sb.size() > 0) begin
                chk("rnd_data", 64'(out_data), 64'(sb[0][50:3]));
                chk("rnd_last", 64'(out_last), 64'(sb[0][2]));
                chk("rnd_mode", 64'(out_mode), 64'(sb[0][1:0]));
                m_shown = sb[0][50:3];
            end else begin
                chk("rnd_hold", 64'(out_data), 64'(m_shown));
            end
            chk("rnd_in_ready", 64'(in_ready), 64'(sb.size() < 2));
            chk("rnd_beat_cnt", 64'(beat_cnt), 64'(m_cnt));
            acc_now = in_valid && (sb.size() < 2);
            if ((sb.size() > 0) && out_ready) void'(sb.pop_front());
            if (acc_now) begin
                eff = m_in_frame ? m_fmode : mode;
                sb.push_back({ref_swap(in_data, eff), in_last, eff});
                if (!m_in_frame && !in_last) begin
                    m_in_frame = 1'b1;
                    m_fmode    = mode;
                end else if (m_in_frame && in_last) begin
                    m_in_frame = 1'b0;
                end
            end
            if (clr_cnt) m_cnt = '0;
            else if (acc_now && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; clr_cnt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
